// File: rtl/candy_stepper_driver.sv
// Stepper pulse generator for the candy dispenser: turns one accepted
// dispense command into a dir-setup delay followed by a timed step pulse train.
module candy_stepper_driver #(
    parameter int STEPS_PER_UNIT     = 200,
    parameter int STEP_HIGH_CYCLES   = 12,
    parameter int STEP_PERIOD_CYCLES = 6000,
    parameter int DIR_SETUP_CYCLES   = 24,
    parameter int CNT_W              = 10
) (
    input  logic             clk_x1,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_amount,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cmd_err,
    output logic [CNT_W-1:0] step_count
);

    localparam int TMR_W = $clog2(STEP_PERIOD_CYCLES + DIR_SETUP_CYCLES);

    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] HI_LOAD    = TMR_W'(STEP_HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] LO_LOAD    = TMR_W'(STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES - 1);

    localparam logic [CNT_W-1:0] STEPS_1 = CNT_W'(STEPS_PER_UNIT);
    localparam logic [CNT_W-1:0] STEPS_2 = CNT_W'(2 * STEPS_PER_UNIT);
    localparam logic [CNT_W-1:0] STEPS_3 = CNT_W'(3 * STEPS_PER_UNIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic [CNT_W-1:0] remaining, remaining_d;
    logic [CNT_W-1:0] count_d, count_inc;
    logic             step_d, dir_d, aborted_d, cmd_err_d;
    logic             abort_pend, abort_pend_d;

    assign count_inc = (step_count == CNT_MAX) ? step_count : step_count + CNT_W'(1);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SETUP) || (state == PULSE_HI) || (state == PULSE_LO);
    assign done      = (state == DONE);

    always_ff @(posedge clk_x1) begin
        if (!rstn) begin
            state      <= IDLE;
            timer      <= '0;
            remaining  <= '0;
            step_count <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            aborted    <= 1'b0;
            cmd_err    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            remaining  <= remaining_d;
            step_count <= count_d;
            step       <= step_d;
            dir        <= dir_d;
            aborted    <= aborted_d;
            cmd_err    <= cmd_err_d;
            abort_pend <= abort_pend_d;
        end
    end

    // An abort seen during the high phase is remembered so the pulse is never truncated.
    always_comb begin
        state_d      = state;
        timer_d      = timer;
        remaining_d  = remaining;
        count_d      = step_count;
        step_d       = step;
        dir_d        = dir;
        aborted_d    = aborted;
        cmd_err_d    = 1'b0;
        abort_pend_d = abort_pend;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_amount == 2'b11) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        dir_d        = cmd_dir;
                        count_d      = '0;
                        aborted_d    = 1'b0;
                        abort_pend_d = 1'b0;
                        timer_d      = SETUP_LOAD;
                        state_d      = SETUP;
                        case (cmd_amount)
                            2'b00:   remaining_d = STEPS_1;
                            2'b01:   remaining_d = STEPS_2;
                            default: remaining_d = STEPS_3;
                        endcase
                    end
                end
            end

            SETUP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (timer == '0) begin
                    step_d  = 1'b1;
                    timer_d = HI_LOAD;
                    state_d = PULSE_HI;
                end else begin
                    timer_d = timer - TMR_W'(1);
                end
            end

            PULSE_HI: begin
                if (timer == '0) begin
                    step_d = 1'b0;
                    if (abort_pend || abort) begin
                        count_d     = count_inc;
                        remaining_d = remaining - CNT_W'(1);
                        aborted_d   = 1'b1;
                        state_d     = DONE;
                    end else begin
                        timer_d = LO_LOAD;
                        state_d = PULSE_LO;
                    end
                end else begin
                    timer_d = timer - TMR_W'(1);
                    if (abort) begin
                        abort_pend_d = 1'b1;
                    end
                end
            end

            // Normal completion on the last low cycle takes priority over abort.
            PULSE_LO: begin
                if (timer == '0) begin
                    count_d     = count_inc;
                    remaining_d = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (abort) begin
                        aborted_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        step_d  = 1'b1;
                        timer_d = HI_LOAD;
                        state_d = PULSE_HI;
                    end
                end else if (abort) begin
                    count_d     = count_inc;
                    remaining_d = remaining - CNT_W'(1);
                    aborted_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    timer_d = timer - TMR_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_candy_stepper_driver.sv
// Scoreboard bench for candy_stepper_driver: stimulus queues the expected
// outcome of each command, a negedge monitor checks it when done pulses.
module tb_candy_stepper_driver;

    localparam int SPU = 4;
    localparam int H   = 2;
    localparam int P   = 5;
    localparam int D   = 3;
    localparam int CW  = 10;

    logic          clk_x1 = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_amount = 2'b00;
    logic          cmd_dir = 1'b0;
    logic          abort = 1'b0;
    logic          step, dir, busy, done, aborted, cmd_err;
    logic [CW-1:0] step_count;

    candy_stepper_driver #(
        .STEPS_PER_UNIT(SPU),
        .STEP_HIGH_CYCLES(H),
        .STEP_PERIOD_CYCLES(P),
        .DIR_SETUP_CYCLES(D),
        .CNT_W(CW)
    ) dut (
        .clk_x1(clk_x1),
        .rstn(rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_amount(cmd_amount),
        .cmd_dir(cmd_dir),
        .abort(abort),
        .step(step),
        .dir(dir),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .cmd_err(cmd_err),
        .step_count(step_count)
    );

    always #5 clk_x1 = ~clk_x1;

    typedef struct {
        int count;
        int aborted;
        int pulses;
        int busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   err_expected = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    task automatic applyStimulus(input logic [1:0] amt, input logic d);
        @(negedge clk_x1);
        cmd_valid  = 1'b1;
        cmd_amount = amt;
        cmd_dir    = d;
        @(negedge clk_x1);
        cmd_valid  = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk_x1);
            n++;
        end
        if (done !== 1'b1) timeoutFail("wait_done");
    endtask

    task automatic waitStep(input logic level, input int limit);
        int   n;
        logic p;
        n = 0;
        do begin
            p = step;
            @(negedge clk_x1);
            n++;
        end while (!(step === level && p === ~level) && n < limit);
        if (step !== level) timeoutFail("wait_step_edge");
    endtask

    // Monitor: measures every busy window and pulse shape, compares at done.
    int   busy_cnt = 0, pulses = 0, high_run = 0, low_run = 0;
    logic prev_busy = 1'b0, prev_step = 1'b0, dir_bad = 1'b0, start_dir = 1'b0;

    initial begin
        forever begin
            @(negedge clk_x1);
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                busy_cnt  = 0;
                pulses    = 0;
                dir_bad   = 1'b0;
                start_dir = dir;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (dir !== start_dir) dir_bad = 1'b1;
            end
            if (step === 1'b1 && prev_step !== 1'b1) begin
                if (busy === 1'b1 && pulses == 0) checkOutput("setup_len", busy_cnt, D + 1);
                if (busy === 1'b1 && pulses > 0) checkOutput("low_len", low_run, P - H);
                pulses++;
                high_run = 0;
            end
            if (step === 1'b0 && prev_step === 1'b1) begin
                if (busy === 1'b1 || done === 1'b1) checkOutput("high_len", high_run, H);
                low_run = 0;
            end
            if (step === 1'b1) high_run++;
            else low_run++;
            if (cmd_err === 1'b1) begin
                if (err_expected > 0) begin
                    checks++;
                    err_expected--;
                end else begin
                    checkOutput("unexpected_cmd_err", 1, 0);
                end
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("step_count", int'(step_count), cur.count);
                    checkOutput("aborted", int'(aborted), cur.aborted);
                    checkOutput("pulses", pulses, cur.pulses);
                    checkOutput("busy_cycles", busy_cnt, cur.busy_cycles);
                    checkOutput("dir_changed_while_busy", int'(dir_bad), 0);
                    checkOutput("ready_in_done", int'(cmd_ready), 0);
                end
            end
            prev_busy = busy;
            prev_step = step;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk_x1);
        checkOutput("rst_step", int'(step), 0);
        checkOutput("rst_dir", int'(dir), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_aborted", int'(aborted), 0);
        checkOutput("rst_cmd_err", int'(cmd_err), 0);
        checkOutput("rst_step_count", int'(step_count), 0);
        checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
        rstn = 1'b1;
        @(negedge clk_x1);

        // Two units, dir=1: 8 pulses, busy 3 + 8*5
        exp_q.push_back('{8, 0, 8, 43});
        applyStimulus(2'b01, 1'b1);
        checkOutput("dir_latched", int'(dir), 1);
        checkOutput("busy_after_accept", int'(busy), 1);
        waitDone(100);
        repeat (2) @(negedge clk_x1);

        // One unit, then three units held valid through DONE
        exp_q.push_back('{4, 0, 4, 23});
        applyStimulus(2'b00, 1'b1);
        exp_q.push_back('{12, 0, 12, 63});
        cmd_valid  = 1'b1;
        cmd_amount = 2'b10;
        cmd_dir    = 1'b0;
        waitDone(100);
        n = 0;
        do begin
            @(negedge clk_x1);
            n++;
        end while (busy !== 1'b1 && n < 10);
        checkOutput("b2b_gap", n, 2);
        cmd_valid = 1'b0;
        checkOutput("dir_b2b", int'(dir), 0);
        waitDone(200);
        repeat (2) @(negedge clk_x1);

        // Illegal amount while idle
        err_expected++;
        applyStimulus(2'b11, 1'b1);
        repeat (3) @(negedge clk_x1);
        checkOutput("err_busy", int'(busy), 0);
        checkOutput("err_dir", int'(dir), 0);
        checkOutput("err_step", int'(step), 0);
        checkOutput("err_step_count", int'(step_count), 12);
        checkOutput("err_ready", int'(cmd_ready), 1);

        // Abort in the first cycle of the third high phase
        exp_q.push_back('{3, 1, 3, 15});
        applyStimulus(2'b10, 1'b1);
        repeat (3) waitStep(1'b1, 50);
        abort = 1'b1;
        @(negedge clk_x1);
        abort = 1'b0;
        waitDone(50);
        repeat (2) @(negedge clk_x1);

        // Abort on the final low cycle: normal completion wins
        exp_q.push_back('{4, 0, 4, 23});
        applyStimulus(2'b00, 1'b0);
        repeat (4) waitStep(1'b1, 50);
        waitStep(1'b0, 50);
        repeat (2) @(negedge clk_x1);
        abort = 1'b1;
        @(negedge clk_x1);
        abort = 1'b0;
        waitDone(50);
        repeat (2) @(negedge clk_x1);

        // Reset during a high phase: no done, everything cleared
        applyStimulus(2'b01, 1'b1);
        waitStep(1'b1, 50);
        rstn = 1'b0;
        @(negedge clk_x1);
        checkOutput("mid_rst_step", int'(step), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_step_count", int'(step_count), 0);
        checkOutput("mid_rst_done", int'(done), 0);
        rstn = 1'b1;
        @(negedge clk_x1);
        checkOutput("post_rst_ready", int'(cmd_ready), 1);
        repeat (60) @(negedge clk_x1);

        checkOutput("pending_expected_done", exp_q.size(), 0);
        checkOutput("pending_expected_cmd_err", err_expected, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/candy_stepper_driver.md
Name: candy_stepper_driver

Overview:
- Downstream stage of the candy dispense controller. Converts one accepted dispense command (amount code + direction) into a timed step/dir pulse train for the external stepper driver (IO_D9 step, IO_A10 dir).
- Owns pulse timing, direction setup time, step counting, abort and completion signalling.
- The controller only issues commands and waits for done.

Parameters:
- STEPS_PER_UNIT, 200: steps per candy unit; total steps = units * STEPS_PER_UNIT; 3*STEPS_PER_UNIT must be < 2^CNT_W.
- STEP_HIGH_CYCLES, 12: clocks step is held high per pulse; must be >= 1.
- STEP_PERIOD_CYCLES, 6000: clocks per full step period (high + low); must be > STEP_HIGH_CYCLES.
- DIR_SETUP_CYCLES, 24: clocks dir is held stable before the first step rises; must be >= 1.
- CNT_W, 10: width of step counters.

Ports:
- clk_x1  in  1  12 MHz system clock; all logic is on the rising edge.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request from the dispense controller.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_amount  in  2  00 = 1 unit, 01 = 2 units, 10 = 3 units, 11 = illegal.
- cmd_dir  in  1  requested rotation direction.
- abort  in  1  level; stops the current command early.
- step  out  1  registered step pulse to the stepper driver.
- dir  out  1  registered direction to the stepper driver.
- busy  out  1  high while a command is executing (SETUP, PULSE_HI, PULSE_LO).
- done  out  1  one-cycle pulse when a command ends.
- aborted  out  1  valid with done: 1 = ended by abort.
- cmd_err  out  1  one-cycle pulse when cmd_amount = 11 is presented while ready.
- step_count  out  CNT_W  completed pulses of the current or last command.

Behaviour:
- Reset (rstn low at a rising edge):
  - state = IDLE.
  - step, dir, busy, done, aborted, cmd_err and step_count are all 0; cmd_ready = 1.
  - Reset mid-operation takes effect on that edge: step drops immediately and no done pulse is issued.
- States: IDLE, SETUP, PULSE_HI, PULSE_LO, DONE.
- IDLE, valid command accepted at edge k:
  - Latch dir <= cmd_dir.
  - remaining <= units * STEPS_PER_UNIT; step_count <= 0.
  - busy <= 1; go to SETUP.
- IDLE, illegal command (cmd_valid with amount 11):
  - Not accepted; cmd_err pulses for 1 cycle.
  - Stay in IDLE; dir and step_count are unchanged.
- SETUP: lasts DIR_SETUP_CYCLES cycles, then PULSE_HI. The first step rises on edge k + DIR_SETUP_CYCLES.
- PULSE_HI: step = 1 for STEP_HIGH_CYCLES cycles, then PULSE_LO.
- PULSE_LO: step = 0 for STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES cycles. On the last cycle:
  - step_count increments and remaining decrements.
  - If remaining reaches 0, go to DONE; otherwise go to PULSE_HI.
- DONE: done = 1 for exactly one cycle; busy = 0 and cmd_ready = 0 in this cycle. Next state is IDLE.
- Busy window: busy is high for DIR_SETUP_CYCLES + N*STEP_PERIOD_CYCLES cycles, where N = total steps.
- dir stability: dir never changes while busy; cmd_dir is ignored unless a command is accepted.
- Abort sampled high:
  - In SETUP or PULSE_LO: go to DONE on the next edge. A pulse cut during its LO phase is still counted, because its high phase completed.
  - In PULSE_HI: finish the full high phase, then go to DONE, counting that step. No truncated step pulse is ever emitted.
  - In IDLE or DONE: ignored.
  - aborted = 1 with done; it holds until the next accepted command clears it.
- Simultaneous abort and the final LO cycle: normal completion wins (aborted = 0).
- Back-to-back commands: cmd_valid held high during DONE is accepted on the first IDLE edge. Minimum gap is 2 cycles from the last step low-phase end to the new busy.
- step_count holds its final value after done until the next accepted command; it saturates at 2^CNT_W-1 and never wraps.

Test Plan (STEPS_PER_UNIT=4, STEP_HIGH_CYCLES=2, STEP_PERIOD_CYCLES=5, DIR_SETUP_CYCLES=3):
- Reset, then cmd amount=01, dir=1 at edge k -> dir=1 after edge k; first step high at edge k+3; 8 pulses, each 2 high / 3 low; busy high for 43 cycles; done pulses once; step_count=8; aborted=0.
- amount=00, then (after done) amount=10 with dir=0 held in cmd_valid -> 4 pulses then 12 pulses; dir toggles only while in IDLE; second command accepted 2 cycles after the first's last low phase ends.
- amount=11 while idle -> cmd_err 1-cycle pulse; busy stays 0; no step; dir unchanged.
- amount=10; abort asserted in the 1st cycle of the 3rd PULSE_HI -> step stays high 2 full cycles, then done with aborted=1; step_count=3.
- amount=00; abort on the final PULSE_LO cycle -> done, aborted=0, step_count=4.
- rstn low mid-PULSE_HI -> step, busy and step_count are 0 after that edge; no done; cmd_ready=1 after reset releases.
